// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Bubble word placed in IF/ID on flush or redirect
  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  // Default PC loaded on reset
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus8;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with reset, bubble clear and load enable
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] instr_in,
  input  logic [WIDTH-1:0] pc_plus8_in,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_plus8_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_plus8_q, pc_plus8_d;
  logic             valid_q, valid_d;

  // Clear (bubble) beats enable; with neither, the register holds
  always_comb begin
    instr_d    = instr_q;
    pc_plus8_d = pc_plus8_q;
    valid_d    = valid_q;
    if (clear) begin
      instr_d    = WIDTH'(NOP_INSTR);
      pc_plus8_d = '0;
      valid_d    = 1'b0;
    end else if (enable) begin
      instr_d    = instr_in;
      pc_plus8_d = pc_plus8_in;
      valid_d    = 1'b1;
    end
  end

  // Register update; reset outranks everything
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= WIDTH'(NOP_INSTR);
      pc_plus8_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus8_q <= pc_plus8_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus8_o = pc_plus8_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC selection and IF/ID register of the core
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             branch_taken_e,
  input  logic [WIDTH-1:0] branch_target_e,
  input  logic             pc_src_w,
  input  logic [WIDTH-1:0] result_w,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_plus8_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] fetch_count
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_plus4_f;
  logic [WIDTH-1:0] pc_plus8_f;
  logic             redirect;
  logic             ifid_clear;
  logic             ifid_load;

  assign pc_plus4_f = pc_q + WIDTH'(4);
  assign pc_plus8_f = pc_plus4_f + WIDTH'(4);
  assign redirect   = branch_taken_e | pc_src_w;
  assign ifid_clear = flush_d | redirect;
  assign ifid_load  = ~ifid_clear & ~stall_d;
  assign imem_addr  = pc_q;

  // Next PC: execute branch beats writeback redirect; either overrides stall_f
  always_comb begin
    pc_d = pc_plus4_f;
    if (branch_taken_e) begin
      pc_d = branch_target_e;
    end else if (pc_src_w) begin
      pc_d = result_w;
    end else if (stall_f) begin
      pc_d = pc_q;
    end
  end

  // Count instructions loaded into IF/ID, sticking at the top value
  always_comb begin
    cnt_d = cnt_q;
    if (ifid_load && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // PC and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;

  ifid_reg #(
    .WIDTH(WIDTH)
  ) u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .clear      (ifid_clear),
    .enable     (~stall_d),
    .instr_in   (imem_rdata),
    .pc_plus8_in(pc_plus8_f),
    .instr_o    (instr_d),
    .pc_plus8_o (pc_plus8_d),
    .valid_o    (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             branch_taken_e;
  logic [WIDTH-1:0] branch_target_e;
  logic             pc_src_w;
  logic [WIDTH-1:0] result_w;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] instr_d;
  logic [WIDTH-1:0] pc_plus8_d;
  logic             valid_d;
  logic [CNT_W-1:0] fetch_count;

  int errors;
  int checks;

  fetch_stage #(
    .WIDTH   (WIDTH),
    .RESET_PC(32'h0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .branch_taken_e (branch_taken_e),
    .branch_target_e(branch_target_e),
    .pc_src_w       (pc_src_w),
    .result_w       (result_w),
    .imem_rdata     (imem_rdata),
    .imem_addr      (imem_addr),
    .instr_d        (instr_d),
    .pc_plus8_d     (pc_plus8_d),
    .valid_d        (valid_d),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at address A is 0xE000_0000 + A
  always_comb imem_rdata = 32'hE000_0000 + imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_f         = 1'b0;
    stall_d         = 1'b0;
    flush_d         = 1'b0;
    branch_taken_e  = 1'b0;
    branch_target_e = '0;
    pc_src_w        = 1'b0;
    result_w        = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr_d); end
    checks++; if (pc_plus8_d !== 32'h0) begin errors++; $display("FAIL reset_pc8 got=%h exp=0", pc_plus8_d); end
    checks++; if (fetch_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
      checks++; if (instr_d !== 32'hE000_0000 + 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, instr_d, 32'hE000_0000 + 32'(4 * (i - 1))); end
      checks++; if (pc_plus8_d !== 32'(4 * (i - 1) + 8)) begin errors++; $display("FAIL seq_pc8[%0d] got=%h exp=%h", i, pc_plus8_d, 32'(4 * (i - 1) + 8)); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, valid_d); end
      checks++; if (fetch_count !== 4'(i)) begin errors++; $display("FAIL seq_count[%0d] got=%0d exp=%0d", i, fetch_count, i); end
    end
  endtask

  task automatic test_branch();
    tick();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_pre_addr got=%h exp=10", imem_addr); end
    branch_taken_e  = 1'b1;
    branch_target_e = 32'h100;
    tick();
    clear_inputs();
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr got=%h exp=100", imem_addr); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL br_bubble_valid got=%b exp=0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL br_bubble_instr got=%h exp=0", instr_d); end
    checks++; if (fetch_count !== 4'd4) begin errors++; $display("FAIL br_bubble_count got=%0d exp=4", fetch_count); end
    tick();
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL br_next_addr got=%h exp=104", imem_addr); end
    checks++; if (instr_d !== 32'hE000_0100) begin errors++; $display("FAIL br_target_instr got=%h exp=e0000100", instr_d); end
    checks++; if (pc_plus8_d !== 32'h108) begin errors++; $display("FAIL br_target_pc8 got=%h exp=108", pc_plus8_d); end
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL br_target_valid got=%b exp=1", valid_d); end
    checks++; if (fetch_count !== 4'd5) begin errors++; $display("FAIL br_target_count got=%0d exp=5", fetch_count); end
  endtask

  task automatic test_dual_redirect();
    branch_taken_e  = 1'b1;
    branch_target_e = 32'h200;
    pc_src_w        = 1'b1;
    result_w        = 32'h300;
    tick();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL dual_addr got=%h exp=200", imem_addr); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL dual_valid got=%b exp=0", valid_d); end
    branch_target_e = 32'h200;
    stall_f         = 1'b1;
    stall_d         = 1'b1;
    tick();
    clear_inputs();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL dual_stall_addr got=%h exp=200", imem_addr); end
    checks++; if (fetch_count !== 4'd5) begin errors++; $display("FAIL dual_stall_count got=%0d exp=5", fetch_count); end
    tick();
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL dual_next_addr got=%h exp=204", imem_addr); end
    checks++; if (instr_d !== 32'hE000_0200) begin errors++; $display("FAIL dual_instr got=%h exp=e0000200", instr_d); end
    checks++; if (fetch_count !== 4'd6) begin errors++; $display("FAIL dual_count got=%0d exp=6", fetch_count); end
  endtask

  task automatic test_stall();
    pc_src_w = 1'b1;
    result_w = 32'h1C;
    tick();
    clear_inputs();
    tick();
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL stall_pre_addr got=%h exp=20", imem_addr); end
    checks++; if (instr_d !== 32'hE000_001C) begin errors++; $display("FAIL stall_pre_instr got=%h exp=e000001c", instr_d); end
    stall_f = 1'b1;
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=20", i, imem_addr); end
      checks++; if (instr_d !== 32'hE000_001C) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=e000001c", i, instr_d); end
      checks++; if (fetch_count !== 4'd7) begin errors++; $display("FAIL stall_count[%0d] got=%0d exp=7", i, fetch_count); end
    end
    clear_inputs();
    tick();
    checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL stall_rel_addr got=%h exp=24", imem_addr); end
    checks++; if (instr_d !== 32'hE000_0020) begin errors++; $display("FAIL stall_rel_instr got=%h exp=e0000020", instr_d); end
    checks++; if (pc_plus8_d !== 32'h28) begin errors++; $display("FAIL stall_rel_pc8 got=%h exp=28", pc_plus8_d); end
    checks++; if (fetch_count !== 4'd8) begin errors++; $display("FAIL stall_rel_count got=%0d exp=8", fetch_count); end
  endtask

  task automatic test_flush_stall();
    flush_d = 1'b1;
    stall_d = 1'b1;
    tick();
    clear_inputs();
    checks++; if (imem_addr !== 32'h28) begin errors++; $display("FAIL flush_addr got=%h exp=28", imem_addr); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL flush_instr got=%h exp=0", instr_d); end
    checks++; if (pc_plus8_d !== 32'h0) begin errors++; $display("FAIL flush_pc8 got=%h exp=0", pc_plus8_d); end
    checks++; if (fetch_count !== 4'd8) begin errors++; $display("FAIL flush_count got=%0d exp=8", fetch_count); end
  endtask

  task automatic test_wrap();
    pc_src_w = 1'b1;
    result_w = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_addr got=%h exp=fffffffc", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    checks++; if (instr_d !== 32'hDFFF_FFFC) begin errors++; $display("FAIL wrap_instr got=%h exp=dffffffc", instr_d); end
    checks++; if (pc_plus8_d !== 32'h4) begin errors++; $display("FAIL wrap_pc8 got=%h exp=4", pc_plus8_d); end
    checks++; if (fetch_count !== 4'd9) begin errors++; $display("FAIL wrap_count got=%0d exp=9", fetch_count); end
  endtask

  task automatic test_reset_mid_stall();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++; if (fetch_count !== 4'd5) begin errors++; $display("FAIL rst_pre_count got=%0d exp=5", fetch_count); end
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL rst_pre_addr got=%h exp=14", imem_addr); end
    stall_f = 1'b1;
    stall_d = 1'b1;
    tick();
    checks++; if (fetch_count !== 4'd5) begin errors++; $display("FAIL rst_stall_count got=%0d exp=5", fetch_count); end
    reset           = 1'b1;
    branch_taken_e  = 1'b1;
    branch_target_e = 32'h500;
    tick();
    clear_inputs();
    reset = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got=%h exp=0", imem_addr); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL rst_mid_instr got=%h exp=0", instr_d); end
    checks++; if (fetch_count !== 4'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_misaligned();
    branch_taken_e  = 1'b1;
    branch_target_e = 32'h103;
    tick();
    clear_inputs();
    checks++; if (imem_addr !== 32'h103) begin errors++; $display("FAIL mis_addr got=%h exp=103", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h107) begin errors++; $display("FAIL mis_next_addr got=%h exp=107", imem_addr); end
    checks++; if (instr_d !== 32'hE000_0103) begin errors++; $display("FAIL mis_instr got=%h exp=e0000103", instr_d); end
    checks++; if (pc_plus8_d !== 32'h10B) begin errors++; $display("FAIL mis_pc8 got=%h exp=10b", pc_plus8_d); end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    checks++; if (fetch_count !== 4'd15) begin errors++; $display("FAIL sat_max_count got=%0d exp=15", fetch_count); end
    tick();
    checks++; if (fetch_count !== 4'd15) begin errors++; $display("FAIL sat_hold_count got=%0d exp=15", fetch_count); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL sat_addr got=%h exp=40", imem_addr); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_dual_redirect();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_reset_mid_stall();
    test_misaligned();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined core. Holds the program counter, drives the instruction memory address, and selects the next PC among sequential, writeback-redirect and execute-branch targets. Registers the fetched instruction into the IF/ID pipeline register consumed by the decoder. Honours stall and flush requests from the hazard unit.

## Interface
- WIDTH, 32, datapath and address width
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of fetch counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_f  in  1  hold PC (hazard unit)
- stall_d  in  1  hold IF/ID register (hazard unit)
- flush_d  in  1  load bubble into IF/ID (hazard unit)
- branch_taken_e  in  1  branch resolved taken in execute
- branch_target_e  in  WIDTH  branch target from ALU
- pc_src_w  in  1  writeback writes R15
- result_w  in  WIDTH  writeback result (new PC when pc_src_w)
- imem_rdata  in  WIDTH  instruction word, combinational read of imem_addr
- imem_addr  out  WIDTH  current PC, combinational from PC register
- instr_d  out  WIDTH  instruction in IF/ID
- pc_plus8_d  out  WIDTH  PC+8 of instruction in IF/ID (R15 read value)
- valid_d  out  1  IF/ID holds a real instruction
- fetch_count  out  CNT_W  number of valid instructions accepted into IF/ID

## Operation
- pc_plus4_f = pc_f + 4, modulo 2^WIDTH (wrap at all-ones, no flag).
- Next-PC priority: reset > branch_taken_e (branch_target_e) > pc_src_w (result_w) > stall_f (hold) > pc_plus4_f.
- Redirect (branch_taken_e or pc_src_w) loads the PC even when stall_f = 1.
- IF/ID update priority: reset > (flush_d or redirect) > stall_d > load.
  - Bubble: instr_d = NOP (0), valid_d = 0, pc_plus8_d = 0.
  - Hold: all IF/ID outputs unchanged.
  - Load: instr_d = imem_rdata, pc_plus8_d = pc_plus4_f + 4, valid_d = 1.
- Flush wins over stall_d in the same cycle.
- fetch_count increments on every Load; saturates at 2^CNT_W−1; unchanged on hold/bubble.
- Low two PC bits are not forced; misaligned targets propagate unchanged.

## Timing
- Reset (any cycle, including mid-stall or mid-redirect): next edge sets pc_f = RESET_PC, instr_d = 0, pc_plus8_d = 0, valid_d = 0, fetch_count = 0; all other inputs ignored that cycle.
- imem_addr = pc_f with zero latency; imem_rdata sampled same cycle.
- Fetch-to-decode latency: 1 cycle (instruction at PC X on imem_addr in cycle n appears on instr_d in cycle n+1).
- Redirect in cycle n: pc_f = target in n+1; IF/ID holds bubble in n+1; target instruction on instr_d in n+2.
- Redirect penalty from sequential stream: one bubble from this block; additional bubbles for younger stages are the hazard unit's responsibility.
- stall_f and stall_d asserted together for k cycles: pc_f and IF/ID frozen for k cycles, stream resumes without loss or duplication.
- stall_f alone with stall_d = 0: IF/ID reloads the same PC's instruction each cycle (duplicate); hazard unit must not issue this combination except with flush_d.

## Structure
- Package fetch_pkg: NOP_INSTR constant, RESET_PC default, ifid_t struct (instr, pc_plus8, valid).
- Sub-module ifid_reg: IF/ID register with synchronous reset, clear and enable, parameterised on WIDTH; top-level holds PC register, next-PC mux, adders and counter.

## Test plan
- Reset then 4 free-running cycles, imem returns 0xE000_0000+PC -> imem_addr 0,4,8,12; instr_d 0xE000_0000..0xE000_0008 from cycle 2; pc_plus8_d 8,12,16; fetch_count 3.
- branch_taken_e = 1, target 0x100 at PC 0x10 -> next imem_addr 0x100, valid_d = 0 one cycle, then instr at 0x100 with pc_plus8_d 0x108.
- branch_taken_e and pc_src_w together (targets 0x200, 0x300) -> PC = 0x200; both with stall_f = 1 -> still 0x200.
- stall_f = stall_d = 1 for 3 cycles at PC 0x20 -> imem_addr stays 0x20, instr_d/fetch_count frozen; release -> 0x24 next, no duplicate.
- flush_d and stall_d together -> bubble (valid_d 0, instr_d 0), count unchanged; PC at 0xFFFF_FFFC with no stall -> wraps to 0x0.
- reset asserted during a stall with fetch_count 5 -> next cycle PC = RESET_PC, valid_d 0, fetch_count 0.
